ofmap_packer: RTL and testbench

Downstream stage of the accelerator top: consumes the post-processed output stream (`valid`/`ofmap`) one sample per cycle and packs it into 32-bit DRAM write words. In quantized mode four 8-bit results pack little-endian into one word. In raw mode each 32-bit partial sum passes through as its own word. Words are buffered in a small FIFO and drained over a valid/ready write port with an incrementing word address. A flush on end-of-layer emits any partial word with byte strobes and then signals completion.

---
 rtl/ofmap_packer.sv | 179 +++++++++++++++++
 tb/tb_ofmap_packer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_packer.sv
// Packs the post-processed output stream into 32-bit DRAM write words and drains
// them through a small word FIFO over a valid/ready port with incrementing addresses.
module ofmap_packer #(
  parameter int unsigned         FIFO_DEPTH = 8,
  parameter int unsigned         ADDR_W     = 12,
  parameter logic [ADDR_W-1:0]   BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_mode,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [3:0]        out_strb,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 36;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         buf_q, buf_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

  logic                pop, full, can_push, push, accept, eff_mode;
  logic [31:0]         push_data;
  logic [3:0]          push_strb;

  assign pop      = (count_q != '0) && out_ready;
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign can_push = !full || pop;
  // The first sample of a run is interpreted with the live mode pin.
  assign eff_mode = (state_q == IDLE) ? raw_mode : mode_q;

  // Next-state, packing and push decisions.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lane_d    = lane_q;
    buf_d     = buf_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_data = 32'h0;
    push_strb = 4'h0;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = raw_mode;
          accept  = 1'b1;
          state_d = in_last ? FLUSH : RUN;
        end else if (in_last) begin
          state_d = FLUSH;
        end
      end
      RUN: begin
        accept = in_valid;
        if (in_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (in_valid) ovf_d = 1'b1;
        if (lane_q != 2'd0) begin
          if (can_push) begin
            push      = 1'b1;
            push_data = {8'h00, buf_q};
            unique case (lane_q)
              2'd1:    push_strb = 4'h1;
              2'd2:    push_strb = 4'h3;
              default: push_strb = 4'h7;
            endcase
            lane_d = 2'd0;
            buf_d  = 24'h0;
          end
        end else if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)) begin
          state_d = DONE;
        end
      end
      default: begin
        if (in_valid) ovf_d = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      if (eff_mode) begin
        if (can_push) begin
          push      = 1'b1;
          push_data = in_data;
          push_strb = 4'hF;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (lane_q == 2'd3) begin
        // A dropped completing byte discards the whole word.
        if (can_push) begin
          push      = 1'b1;
          push_data = {in_data[7:0], buf_q};
          push_strb = 4'hF;
        end else begin
          ovf_d = 1'b1;
        end
        lane_d = 2'd0;
        buf_d  = 24'h0;
      end else begin
        unique case (lane_q)
          2'd0:    buf_d[7:0]   = in_data[7:0];
          2'd1:    buf_d[15:8]  = in_data[7:0];
          default: buf_d[23:16] = in_data[7:0];
        endcase
        lane_d = lane_q + 2'd1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    addr_d = addr_q;
    if (state_q == DONE) addr_d = BASE_ADDR;
    else if (pop)        addr_d = addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      lane_q   <= 2'd0;
      buf_q    <= 24'h0;
      ovf_q    <= 1'b0;
      addr_q   <= BASE_ADDR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      lane_q   <= lane_d;
      buf_q    <= buf_d;
      ovf_q    <= ovf_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_strb, push_data};
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
  assign out_strb  = out_valid ? mem_q[rd_ptr_q][35:32] : 4'h0;
  assign out_addr  = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ofmap_packer.sv
// Self-checking bench for ofmap_packer: queue-based reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_ofmap_packer;

  localparam int unsigned DEPTH = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst, raw_mode, in_valid, in_last, out_ready;
  logic [31:0] in_data;

  logic        out_valid, busy, done, overflow;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic [11:0] out_addr;

  logic        out_valid2, busy2, done2, overflow2;
  logic [31:0] out_data2;
  logic [3:0]  out_strb2;
  logic [1:0]  out_addr2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ofmap_packer #(.FIFO_DEPTH(DEPTH), .ADDR_W(12), .BASE_ADDR(12'd0)) dut (
    .clk(clk), .rst(rst), .raw_mode(raw_mode), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_strb(out_strb), .out_addr(out_addr), .busy(busy), .done(done), .overflow(overflow)
  );

  ofmap_packer #(.FIFO_DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(2'd0)) dut_w (
    .clk(clk), .rst(rst), .raw_mode(raw_mode), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_strb(out_strb2), .out_addr(out_addr2), .busy(busy2), .done(done2), .overflow(overflow2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word queue with spec-level state.
  logic [35:0] q[$];
  int          m_st = M_IDLE;
  int          m_lane = 0;
  logic [7:0]  m_b[4];
  logic        m_mode = 1'b0;
  logic        m_ovf = 1'b0;
  int          m_addr = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    bit          m_pop, can_push, have_push, acc, eff;
    logic [35:0] pw;
    int          prev;
    started = 1'b1;
    if (rst) begin
      q.delete();
      m_st = M_IDLE; m_lane = 0; m_mode = 1'b0; m_ovf = 1'b0; m_addr = 0;
      for (int i = 0; i < 4; i++) m_b[i] = 8'h0;
    end else begin
      prev      = m_st;
      m_pop     = (q.size() != 0) && out_ready;
      can_push  = (q.size() < DEPTH) || m_pop;
      have_push = 1'b0;
      acc       = 1'b0;
      eff       = m_mode;
      pw        = '0;
      case (m_st)
        M_IDLE: begin
          if (in_valid) begin
            m_mode = raw_mode; eff = raw_mode; acc = 1'b1;
            m_st = in_last ? M_FLUSH : M_RUN;
          end else if (in_last) m_st = M_FLUSH;
        end
        M_RUN: begin
          acc = in_valid;
          if (in_last) m_st = M_FLUSH;
        end
        M_FLUSH: begin
          if (in_valid) m_ovf = 1'b1;
          if (m_lane != 0) begin
            if (can_push) begin
              for (int i = 0; i < m_lane; i++) begin
                pw[8*i +: 8] = m_b[i];
                pw[32 + i]   = 1'b1;
              end
              have_push = 1'b1;
              m_lane = 0;
            end
          end else if (q.size() - int'(m_pop) == 0) m_st = M_DONE;
        end
        default: begin
          if (in_valid) m_ovf = 1'b1;
          m_st = M_IDLE;
        end
      endcase
      if (acc) begin
        if (eff) begin
          if (can_push) begin pw = {4'hF, in_data}; have_push = 1'b1; end
          else m_ovf = 1'b1;
        end else if (m_lane == 3) begin
          if (can_push) begin
            pw = {4'hF, in_data[7:0], m_b[2], m_b[1], m_b[0]};
            have_push = 1'b1;
          end else m_ovf = 1'b1;
          m_lane = 0;
        end else begin
          m_b[m_lane] = in_data[7:0];
          m_lane++;
        end
      end
      if (m_pop) begin
        void'(q.pop_front());
        m_addr = (m_addr + 1) % 4096;
      end
      if (prev == M_DONE) m_addr = 0;
      if (have_push) q.push_back(pw);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  es;
    if (started) begin
      ev = (q.size() != 0);
      ed = ev ? q[0][31:0]  : 32'h0;
      es = ev ? q[0][35:32] : 4'h0;
      check("out_valid", 64'(out_valid), 64'(ev));
      check("out_data",  64'(out_data),  64'(ed));
      check("out_strb",  64'(out_strb),  64'(es));
      check("out_addr",  64'(out_addr),  64'(m_addr));
      check("busy",      64'(busy),      64'(m_st != M_IDLE));
      check("done",      64'(done),      64'(m_st == M_DONE));
      check("overflow",  64'(overflow),  64'(m_ovf));
      check("w_data",    64'({out_valid2, out_strb2, out_data2}), 64'({ev, es, ed}));
      check("w_addr",    64'(out_addr2), 64'(m_addr % 4));
    end
  end

  // Accepted-word logs for the directed literal checks.
  logic [47:0] log_q[$];
  logic [1:0]  log2_q[$];
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) log_q.push_back({out_addr, out_strb, out_data});
    if (!rst && out_valid2 && out_ready) log2_q.push_back(out_addr2);
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic l, input logic r);
    @(posedge clk);
    #1;
    in_valid = v; in_data = d; in_last = l; raw_mode = r;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (i + 1 < budget) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1; rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1; rst = 1'b0;
  endtask

  int exp2[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; raw_mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr",  64'(out_addr),  64'd0);
    check("rst_busy",  64'({busy, done, overflow}), 64'd0);
    check("rst_data",  64'({out_strb, out_data}), 64'd0);

    // Pack: two full words, then a lone in_last.
    out_ready = 1'b1; log_q.delete();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    wait_done(40);
    check("pack_n",  64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check("pack_w0", 64'(log_q[0]), 64'({12'd0, 4'hF, 32'h04030201}));
      check("pack_w1", 64'(log_q[1]), 64'({12'd1, 4'hF, 32'h08070605}));
    end

    // Partial flush with in_last on the sixth sample.
    log_q.delete();
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'(8'h11 + i), i == 5, 1'b0);
    wait_done(40);
    check("part_n", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check("part_w0", 64'(log_q[0]), 64'({12'd0, 4'hF, 32'h14131211}));
      check("part_w1", 64'(log_q[1]), 64'({12'd1, 4'h3, 32'h00001615}));
    end

    // Raw mode; raw_mode drops mid-run and must be ignored.
    log_q.delete();
    cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    cyc(1'b1, 32'h12345678, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    wait_done(40);
    check("raw_n", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check("raw_w0", 64'(log_q[0]), 64'({12'd0, 4'hF, 32'hDEADBEEF}));
      check("raw_w1", 64'(log_q[1]), 64'({12'd1, 4'hF, 32'h12345678}));
    end

    // Backpressure: fill the FIFO, the ninth word is dropped.
    log_q.delete(); out_ready = 1'b0;
    for (int i = 0; i < 4 * DEPTH + 4; i++) cyc(1'b1, 32'(i + 1), 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ovf",   64'(overflow),  64'd1);
    check("bp_valid", 64'(out_valid), 64'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    out_ready = 1'b1;
    wait_done(60);
    check("bp_n", 64'(log_q.size()), 64'(DEPTH));
    for (int k = 0; k < DEPTH && k < log_q.size(); k++)
      check("bp_w", 64'(log_q[k]),
            64'({12'(k), 4'hF, 8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}));

    // Address wrap on the 2-bit instance.
    log2_q.delete();
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'(i), 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    wait_done(40);
    check("wrap_n", 64'(log2_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < log2_q.size(); i++)
      check("wrap_addr", 64'(log2_q[i]), 64'(exp2[i]));

    // Reset mid-run, then a clean run from lane 0 / base address.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_flags", 64'({busy, done, overflow}), 64'd0);
    check("mr_addr",  64'(out_addr), 64'd0);
    log_q.delete();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC1 + 32'(i), i == 3, 1'b0);
    wait_done(40);
    check("mr_n", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1)
      check("mr_w0", 64'(log_q[0]), 64'({12'd0, 4'hF, 32'hC4C3C2C1}));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 10) < 6, $urandom, ($urandom % 40) == 0, $urandom % 2);
      out_ready = ((i / 200) % 2 == 0) ? (($urandom % 10) < 7) : (($urandom % 10) < 2);
      rst = (($urandom % 700) == 0);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0; out_ready = 1'b1;
    repeat (30) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    wait_done(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1);
  end

endmodule
